// File: rtl/iosc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// iosc_ctrl_pkg
// Shared types and helpers for the IO crystal-oscillator controller.
//   iosc_state_e : sequencer state encoding, also driven out on state_o
//   width_of()   : counter width able to hold 0..max_val, never narrower than 1
//   DEF_*        : default build parameters of iosc_ctrl
//   CNT_W/ST_W/RTY_W : counter widths for the default build
// -----------------------------------------------------------------------------
package iosc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_START   = 3'd1,
        ST_MEASURE = 3'd2,
        ST_RUN     = 3'd3,
        ST_FAIL    = 3'd4
    } iosc_state_e;

    function automatic int width_of(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int DEF_STARTUP_CYC = 4096;
    localparam int DEF_WIN_CYC     = 256;
    localparam int DEF_MAX_RETRY   = 3;

    localparam int CNT_W = $clog2(DEF_WIN_CYC + 1);
    localparam int ST_W  = $clog2(DEF_STARTUP_CYC + 1);
    localparam int RTY_W = width_of(DEF_MAX_RETRY);

endpackage

// File: rtl/iosc_sync_edge.sv
// -----------------------------------------------------------------------------
// iosc_sync_edge
// Multi-flop synchroniser for an asynchronous pad signal followed by a
// rising-edge detector on its last two stages.
//   clk_i   : sampling clock
//   rst_i   : synchronous active-high reset, clears the synchroniser
//   async_i : asynchronous input from the pad
//   rise_o  : one-cycle pulse, last two stages read 0 (older) then 1 (newer)
// -----------------------------------------------------------------------------
module iosc_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic rise_o
);

    // Stage 0 is the metastability-catching flop, stage SYNC_STAGES-1 the oldest.
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
    end

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge value of its neighbour; blocking here would
    // collapse the shift register into a single flop. The chain is reset so a
    // stale 1 cannot fake an edge right after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/iosc_ctrl.sv
// -----------------------------------------------------------------------------
// iosc_ctrl
// Power-up sequencer and frequency monitor for the IO crystal oscillator pad.
// Releases pad power-down, waits STARTUP_CYC reference cycles, then counts
// oscillator rising edges over back-to-back WIN_CYC windows. A window result
// is judged the cycle after the window closes.
//   clk_i      : always-on reference clock
//   rst_i      : synchronous active-high reset
//   en_i       : level request to run the oscillator
//   clear_i    : one-cycle pulse, leaves FAIL
//   osc_xo_i   : raw asynchronous oscillator output from the pad
//   osc_pd_o   : pad power-down, 1 = oscillator off
//   clk_ok_o   : oscillator qualified and in range
//   lost_o     : one-cycle pulse when an in-range clock drops out of range
//   fail_o     : retries exhausted, held until clear_i or en_i low
//   state_o    : current state encoding (iosc_state_e)
//   edge_cnt_o : edge count of the last completed window
// -----------------------------------------------------------------------------
module iosc_ctrl
    import iosc_ctrl_pkg::*;
#(
    parameter int STARTUP_CYC = DEF_STARTUP_CYC,
    parameter int WIN_CYC     = DEF_WIN_CYC,
    parameter int MIN_EDGES   = 32,
    parameter int MAX_EDGES   = 96,
    parameter int MAX_RETRY   = DEF_MAX_RETRY,
    parameter int SYNC_STAGES = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           en_i,
    input  logic                           clear_i,
    input  logic                           osc_xo_i,
    output logic                           osc_pd_o,
    output logic                           clk_ok_o,
    output logic                           lost_o,
    output logic                           fail_o,
    output logic [2:0]                     state_o,
    output logic [$clog2(WIN_CYC+1)-1:0]   edge_cnt_o
);

    // Widths follow this instance's parameters rather than the package defaults.
    localparam int EC_W = $clog2(WIN_CYC + 1);
    localparam int SC_W = width_of(STARTUP_CYC);
    localparam int RC_W = width_of(MAX_RETRY);

    localparam logic [SC_W-1:0] ST_LAST   = SC_W'(STARTUP_CYC - 1);
    localparam logic [EC_W-1:0] WIN_LAST  = EC_W'(WIN_CYC - 1);
    localparam logic [EC_W-1:0] WIN_SAT   = EC_W'(WIN_CYC);
    localparam logic [EC_W-1:0] MIN_L     = EC_W'(MIN_EDGES);
    localparam logic [EC_W-1:0] MAX_L     = EC_W'(MAX_EDGES);
    localparam logic [RC_W-1:0] RTY_LIMIT = RC_W'(MAX_RETRY);

    iosc_state_e       state_q,    state_d;
    logic [SC_W-1:0]   st_cnt_q,   st_cnt_d;
    logic [RC_W-1:0]   rty_q,      rty_d;
    logic [EC_W-1:0]   win_pos_q,  win_pos_d;
    logic [EC_W-1:0]   acc_q,      acc_d;
    logic [EC_W-1:0]   res_q,      res_d;
    logic              done_q,     done_d;
    logic [EC_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic              lost_q,     lost_d;

    logic              osc_rise;
    logic [EC_W-1:0]   acc_sum;
    logic              win_active;
    logic              in_range;

    iosc_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (osc_xo_i),
        .rise_o  (osc_rise)
    );

    assign win_active = en_i && ((state_q == ST_MEASURE) || (state_q == ST_RUN));
    assign in_range   = (res_q >= MIN_L) && (res_q <= MAX_L);
    // Saturate at WIN_CYC; the count can never wrap back into the pass range.
    assign acc_sum    = (acc_q == WIN_SAT) ? acc_q : acc_q + EC_W'(osc_rise);

    // NOTE: every signal written in this block gets a default first, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        st_cnt_d   = st_cnt_q;
        rty_d      = rty_q;
        win_pos_d  = '0;
        acc_d      = '0;
        res_d      = res_q;
        done_d     = 1'b0;
        edge_cnt_d = edge_cnt_q;
        lost_d     = 1'b0;

        // Window engine: free-running while measuring or running, so windows
        // follow each other with no gap; otherwise held cleared, which also
        // discards any partial window.
        if (win_active) begin
            if (win_pos_q == WIN_LAST) begin
                res_d  = acc_sum;
                done_d = 1'b1;
            end else begin
                acc_d     = acc_sum;
                win_pos_d = win_pos_q + EC_W'(1);
            end
        end

        // Publish the closed window's count the cycle after it closes.
        if (done_q && ((state_q == ST_MEASURE) || (state_q == ST_RUN))) begin
            edge_cnt_d = res_q;
        end

        if (!en_i) begin
            state_d = ST_OFF;
        end else begin
            unique case (state_q)
                ST_OFF: begin
                    state_d  = ST_START;
                    st_cnt_d = '0;
                    rty_d    = '0;
                end
                ST_START: begin
                    if (st_cnt_q == ST_LAST) begin
                        state_d = ST_MEASURE;
                    end else begin
                        st_cnt_d = st_cnt_q + SC_W'(1);
                    end
                end
                ST_MEASURE: begin
                    if (done_q) begin
                        if (in_range) begin
                            state_d = ST_RUN;
                        end else if (rty_q == RTY_LIMIT) begin
                            state_d = ST_FAIL;
                        end else begin
                            rty_d = rty_q + RC_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (done_q && !in_range) begin
                        state_d = ST_MEASURE;
                        lost_d  = 1'b1;
                        rty_d   = '0;
                    end
                end
                ST_FAIL: begin
                    if (clear_i) begin
                        state_d = ST_OFF;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_OFF;
            st_cnt_q   <= '0;
            rty_q      <= '0;
            win_pos_q  <= '0;
            acc_q      <= '0;
            res_q      <= '0;
            done_q     <= 1'b0;
            edge_cnt_q <= '0;
            lost_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            st_cnt_q   <= st_cnt_d;
            rty_q      <= rty_d;
            win_pos_q  <= win_pos_d;
            acc_q      <= acc_d;
            res_q      <= res_d;
            done_q     <= done_d;
            edge_cnt_q <= edge_cnt_d;
            lost_q     <= lost_d;
        end
    end

    assign osc_pd_o   = (state_q == ST_OFF) || (state_q == ST_FAIL);
    assign clk_ok_o   = (state_q == ST_RUN);
    assign fail_o     = (state_q == ST_FAIL);
    assign lost_o     = lost_q;
    assign state_o    = state_q;
    assign edge_cnt_o = edge_cnt_q;

endmodule

// File: tb/tb_iosc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_iosc_ctrl
// Self-checking bench for iosc_ctrl with a small, fast parameter set.
// The oscillator is driven from a WIN-periodic pulse pattern carrying exactly
// k rising edges in any WIN consecutive cycles. A behavioural model tracks the
// expected outputs from the sequencing rules; directed scenarios add latency
// and boundary checks against fixed numbers.
// -----------------------------------------------------------------------------
module tb_iosc_ctrl;

    localparam int STARTUP = 8;
    localparam int WIN     = 16;
    localparam int MIN_E   = 3;
    localparam int MAX_E   = 6;
    localparam int MAX_R   = 1;
    localparam int SYNC    = 2;
    localparam int EW      = $clog2(WIN + 1);

    localparam int M_OFF   = 0;
    localparam int M_START = 1;
    localparam int M_MEAS  = 2;
    localparam int M_RUN   = 3;
    localparam int M_FAIL  = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          en_i;
    logic          clear_i;
    logic          osc_xo_i;
    logic          osc_pd_o;
    logic          clk_ok_o;
    logic          lost_o;
    logic          fail_o;
    logic [2:0]    state_o;
    logic [EW-1:0] edge_cnt_o;

    iosc_ctrl #(
        .STARTUP_CYC (STARTUP),
        .WIN_CYC     (WIN),
        .MIN_EDGES   (MIN_E),
        .MAX_EDGES   (MAX_E),
        .MAX_RETRY   (MAX_R),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .clear_i    (clear_i),
        .osc_xo_i   (osc_xo_i),
        .osc_pd_o   (osc_pd_o),
        .clk_ok_o   (clk_ok_o),
        .lost_o     (lost_o),
        .fail_o     (fail_o),
        .state_o    (state_o),
        .edge_cnt_o (edge_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int k_cur    = 0;
    int ofs      = 0;

    // Reference model state
    int m_state  = M_OFF;
    int m_phase  = 0;     // cycles already spent in START
    int m_retry  = 0;
    int m_acc    = 0;     // edges seen so far in the open window
    int m_pos    = 0;     // cycles elapsed in the open window
    int m_pend   = -1;    // count of a window that just closed, -1 if none
    int m_ecnt   = 0;
    bit m_lost   = 1'b0;
    bit m_samp [SYNC];    // oscillator samples, [0] = most recent edge

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Oscillator level for cycle c carrying k isolated pulses per WIN cycles.
    function automatic bit pat_bit(input int k, input int c);
        int p;
        p = (c + ofs) % WIN;
        for (int i = 0; i < k; i++) begin
            if ((i * WIN) / k == p) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit pass_count(input int n);
        return (n >= MIN_E) && (n <= MAX_E);
    endfunction

    // Advance the model by one reference edge with the inputs seen at that edge.
    task automatic model_edge(input bit rst, input bit en, input bit clr, input bit osc);
        int  nstate, nphase, nretry, nacc, npos, npend, necnt, sum;
        bit  nlost, r;
        if (rst) begin
            m_state = M_OFF; m_phase = 0; m_retry = 0; m_acc = 0; m_pos = 0;
            m_pend = -1; m_ecnt = 0; m_lost = 1'b0;
            for (int i = 0; i < SYNC; i++) m_samp[i] = 1'b0;
            return;
        end
        // An edge counted in this cycle: older sample low, newer sample high.
        r      = m_samp[SYNC-2] && !m_samp[SYNC-1];
        nstate = m_state; nphase = m_phase; nretry = m_retry;
        nacc   = 0; npos = 0; npend = -1; necnt = m_ecnt; nlost = 1'b0;

        if (en && (m_state == M_MEAS || m_state == M_RUN)) begin
            sum = m_acc + int'(r);
            if (sum > WIN) sum = WIN;
            if (m_pos == WIN - 1) npend = sum;
            else begin
                nacc = sum;
                npos = m_pos + 1;
            end
        end
        if (m_pend >= 0 && (m_state == M_MEAS || m_state == M_RUN)) necnt = m_pend;

        if (!en) nstate = M_OFF;
        else begin
            case (m_state)
                M_OFF:   begin nstate = M_START; nphase = 0; nretry = 0; end
                M_START: begin
                    if (m_phase + 1 == STARTUP) nstate = M_MEAS;
                    else nphase = m_phase + 1;
                end
                M_MEAS: if (m_pend >= 0) begin
                    if (pass_count(m_pend)) nstate = M_RUN;
                    else if (m_retry < MAX_R) nretry = m_retry + 1;
                    else nstate = M_FAIL;
                end
                M_RUN: if (m_pend >= 0 && !pass_count(m_pend)) begin
                    nstate = M_MEAS; nlost = 1'b1; nretry = 0;
                end
                M_FAIL: if (clr) nstate = M_OFF;
                default: nstate = M_OFF;
            endcase
        end
        m_state = nstate; m_phase = nphase; m_retry = nretry; m_acc = nacc;
        m_pos = npos; m_pend = npend; m_ecnt = necnt; m_lost = nlost;
        for (int i = SYNC - 1; i > 0; i--) m_samp[i] = m_samp[i-1];
        m_samp[0] = osc;
    endtask

    task automatic compare_all();
        check("state",    int'(state_o),    m_state);
        check("osc_pd",   int'(osc_pd_o),   (m_state == M_OFF || m_state == M_FAIL) ? 1 : 0);
        check("clk_ok",   int'(clk_ok_o),   (m_state == M_RUN) ? 1 : 0);
        check("fail",     int'(fail_o),     (m_state == M_FAIL) ? 1 : 0);
        check("lost",     int'(lost_o),     int'(m_lost));
        check("edge_cnt", int'(edge_cnt_o), m_ecnt);
    endtask

    // One reference cycle: model and DUT see the same edge, outputs are
    // compared 1 time unit later, then the oscillator moves to the next level.
    task automatic step();
        @(posedge clk_i);
        model_edge(rst_i, en_i, clear_i, osc_xo_i);
        #1;
        compare_all();
        cyc++;
        osc_xo_i = pat_bit(k_cur, cyc);
    endtask

    task automatic set_k(input int k);
        k_cur    = k;
        osc_xo_i = pat_bit(k_cur, cyc);
    endtask

    function automatic bit watched(input int what);
        case (what)
            0:       return clk_ok_o;
            1:       return fail_o;
            2:       return lost_o;
            default: return clk_ok_o | fail_o;
        endcase
    endfunction

    // Step until the watched output is high or the budget runs out; n is the
    // number of steps taken.
    task automatic wait_for(input string tag, input int what, input int limit, output int n);
        bit hit;
        n   = 0;
        hit = watched(what);
        while (!hit && n < limit) begin
            step();
            n++;
            hit = watched(what);
        end
        check(tag, int'(hit), 1);
    endtask

    task automatic do_reset();
        rst_i   = 1'b1;
        en_i    = 1'b0;
        clear_i = 1'b0;
        step();
        rst_i   = 1'b0;
    endtask

    int n;
    int seg_len;
    int pick;

    initial begin
        rst_i = 1'b1; en_i = 1'b0; clear_i = 1'b0; osc_xo_i = 1'b0;
        for (int i = 0; i < SYNC; i++) m_samp[i] = 1'b0;
        step();
        step();
        rst_i = 1'b0;
        check("rst_state",  int'(state_o),    0);
        check("rst_osc_pd", int'(osc_pd_o),   1);
        check("rst_clk_ok", int'(clk_ok_o),   0);
        check("rst_edges",  int'(edge_cnt_o), 0);

        // Good oscillator, period 4: 4 edges per window, qualified at cycle 26.
        ofs = 0;
        set_k(4);
        step();
        en_i = 1'b1;
        step();
        check("pd_after_en", int'(osc_pd_o), 0);
        wait_for("wait_ok_first", 0, 60, n);
        check("ok_latency", 1 + n, 26);
        check("ok_edges",   int'(edge_cnt_o), 4);

        // Stuck-low oscillator: one retry, then FAIL at cycle 42; clear to OFF.
        do_reset();
        set_k(0);
        en_i = 1'b1;
        step();
        wait_for("wait_fail", 1, 100, n);
        check("fail_latency", 1 + n, 42);
        check("fail_pd",      int'(osc_pd_o), 1);
        check("fail_clk_ok",  int'(clk_ok_o), 0);
        check("fail_edges",   int'(edge_cnt_o), 0);
        step();
        check("fail_sticky",  int'(fail_o), 1);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        check("clear_to_off", int'(state_o), 0);
        check("clear_fail",   int'(fail_o),  0);
        en_i = 1'b0;
        step();

        // RUN at period 4, speed up to period 2 (8 edges) -> lost, then recover.
        do_reset();
        set_k(4);
        en_i = 1'b1;
        wait_for("wait_ok_run", 0, 60, n);
        set_k(8);
        wait_for("wait_lost", 2, 60, n);
        check("lost_clk_ok", int'(clk_ok_o), 0);
        check("lost_state",  int'(state_o),  2);
        check("lost_edges",  int'(edge_cnt_o), 8);
        step();
        check("lost_pulse",  int'(lost_o), 0);
        set_k(4);
        wait_for("wait_recover", 0, 2 * WIN + 4, n);

        // Pass/fail boundary counts.
        for (int b = 0; b < 4; b++) begin
            int kb;
            case (b)
                0:       kb = 3;
                1:       kb = 6;
                2:       kb = 2;
                default: kb = 7;
            endcase
            do_reset();
            set_k(kb);
            en_i = 1'b1;
            wait_for($sformatf("wait_bound_%0d", kb), 3, 80, n);
            check($sformatf("bound_%0d_ok", kb),    int'(clk_ok_o),   int'(pass_count(kb)));
            check($sformatf("bound_%0d_fail", kb),  int'(fail_o),     int'(!pass_count(kb)));
            check($sformatf("bound_%0d_edges", kb), int'(edge_cnt_o), kb);
        end

        // en_i dropped mid-MEASURE, then mid-RUN.
        do_reset();
        set_k(4);
        en_i = 1'b1;
        for (int i = 0; i < 12; i++) step();
        check("pre_drop_meas", int'(state_o), 2);
        en_i = 1'b0;
        step();
        check("drop_meas_state", int'(state_o),  0);
        check("drop_meas_pd",    int'(osc_pd_o), 1);
        check("drop_meas_flags", int'({clk_ok_o, fail_o, lost_o}), 0);
        en_i = 1'b1;
        wait_for("wait_ok_drop", 0, 60, n);
        step();
        step();
        en_i = 1'b0;
        step();
        check("drop_run_state", int'(state_o),  0);
        check("drop_run_pd",    int'(osc_pd_o), 1);
        check("drop_run_flags", int'({clk_ok_o, fail_o, lost_o}), 0);

        // Reset pulse during START, then the full sequence again from scratch.
        do_reset();
        en_i = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("pre_rst_start", int'(state_o), 1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("rst_mid_state", int'(state_o),  0);
        check("rst_mid_pd",    int'(osc_pd_o), 1);
        check("rst_mid_edges", int'(edge_cnt_o), 0);
        wait_for("wait_ok_rst", 0, 60, n);
        check("rst_reseq_latency", n, 26);

        // Randomised traffic against the model.
        for (int s = 0; s < 60; s++) begin
            seg_len = $urandom_range(5, 60);
            pick    = $urandom_range(0, 11);
            case (pick)
                0:       rst_i   = 1'b1;
                1:       en_i    = 1'b0;
                2:       clear_i = 1'b1;
                default: en_i    = 1'b1;
            endcase
            if ($urandom_range(0, 2) == 0) begin
                ofs = $urandom_range(0, WIN - 1);
                set_k($urandom_range(0, 8));
            end
            step();
            rst_i   = 1'b0;
            clear_i = 1'b0;
            for (int j = 1; j < seg_len; j++) begin
                if ($urandom_range(0, 15) == 0) clear_i = 1'b1;
                if ($urandom_range(0, 40) == 0) en_i = ~en_i;
                step();
                clear_i = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
